// File: rtl/cam_pkg.sv
// Shared CAM definitions: default geometry, request operation codes and the
// insert-controller FSM states, plus the raw-opcode decoder.
package cam_pkg;

   localparam int CAM_DATA_WIDTH = 5;
   localparam int CAM_DATA_SIZE  = 1 << CAM_DATA_WIDTH;

   typedef enum logic [1:0] {
      CAM_OP_LOOKUP = 2'd0,
      CAM_OP_INSERT = 2'd1,
      CAM_OP_DELETE = 2'd2
   } cam_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SEARCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_RESP   = 3'd4
   } cam_state_e;

   // Opcode 3 is reserved and behaves as a lookup.
   function automatic cam_op_e cam_decode_op(input logic [1:0] raw);
      cam_op_e op;
      case (raw)
         2'd1:    op = CAM_OP_INSERT;
         2'd2:    op = CAM_OP_DELETE;
         default: op = CAM_OP_LOOKUP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/cam_insert_ctrl_if.sv
// Request and response valid/ready channels of the CAM insert controller.
// The slave modport is the controller side, master is the requester side.
interface cam_insert_ctrl_if
   import cam_pkg::*;
#(
   parameter int DATA_WIDTH = CAM_DATA_WIDTH,
   parameter int DATA_SIZE  = 1 << DATA_WIDTH
);

   logic                  req_valid;
   logic                  req_ready;
   logic [1:0]            req_op;
   logic [DATA_SIZE-1:0]  req_key;

   logic                  resp_valid;
   logic                  resp_ready;
   logic                  resp_hit;
   logic                  resp_full;
   logic [DATA_WIDTH-1:0] resp_index;

   modport master (
      output req_valid, req_op, req_key, resp_ready,
      input  req_ready, resp_valid, resp_hit, resp_full, resp_index
   );

   modport slave (
      input  req_valid, req_op, req_key, resp_ready,
      output req_ready, resp_valid, resp_hit, resp_full, resp_index
   );

endinterface

// File: rtl/cam_free_pick.sv
// Lowest-free-entry picker: priority encoder over the inverted occupancy vector.
module cam_free_pick
   import cam_pkg::*;
#(
   parameter int DATA_WIDTH = CAM_DATA_WIDTH
) (
   input  logic [(1 << DATA_WIDTH)-1:0] occ,
   output logic [DATA_WIDTH-1:0]        free_index,
   output logic                         any_free
);

   localparam int ENTRIES = 1 << DATA_WIDTH;

   assign any_free = ~(&occ);

   // scan downward so the lowest free entry is the last one written
   always_comb begin
      free_index = {DATA_WIDTH{1'b0}};
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         free_index = occ[i] ? free_index : DATA_WIDTH'(i);
      end
   end

endmodule

// File: rtl/cam_insert_ctrl.sv
// Request-side CAM controller: sequences search/write, tracks occupancy and
// allocates the lowest free entry. Optional CAM_INS_STATS_EN adds hit/miss counters.
module cam_insert_ctrl
   import cam_pkg::*;
#(
   parameter int DATA_WIDTH = CAM_DATA_WIDTH,
   parameter int DATA_SIZE  = 1 << DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   cam_insert_ctrl_if.slave      bus,
   output logic [DATA_WIDTH:0]   occupied_count,
   output logic                  cam_search,
   output logic [DATA_SIZE-1:0]  cam_search_data,
   input  logic                  cam_search_valid,
   input  logic [DATA_WIDTH-1:0] cam_search_index,
   output logic                  cam_write,
   output logic [DATA_WIDTH-1:0] cam_write_index,
   output logic [DATA_SIZE-1:0]  cam_write_data
`ifdef CAM_INS_STATS_EN
   ,
   output logic [15:0]           hit_count,
   output logic [15:0]           miss_count
`endif
);

   localparam int ENTRIES = 1 << DATA_WIDTH;

   cam_state_e            state_r;
   cam_state_e            state_s;
   cam_op_e               op_r;
   logic [DATA_SIZE-1:0]  key_r;
   logic [ENTRIES-1:0]    occ_r;
   logic [DATA_WIDTH:0]   count_r;

   logic                  req_ready_r;
   logic                  resp_valid_r;
   logic                  resp_hit_r;
   logic                  resp_full_r;
   logic [DATA_WIDTH-1:0] resp_index_r;
   logic                  cam_search_r;
   logic [DATA_SIZE-1:0]  cam_search_data_r;
   logic                  cam_write_r;
   logic [DATA_WIDTH-1:0] wr_index_r;
   logic [DATA_SIZE-1:0]  cam_write_data_r;

   logic                  accept_s;
   logic                  ld_wr_s;
   logic [DATA_WIDTH-1:0] wr_idx_s;
   logic                  ld_resp_s;
   logic                  hit_s;
   logic                  full_s;
   logic [DATA_WIDTH-1:0] index_s;
   logic                  occ_set_s;
   logic                  occ_clr_s;
   logic                  hit_match_s;
   logic                  stale_match_s;
   logic                  resp_done_s;
   logic [DATA_WIDTH-1:0] free_index_s;
   logic                  any_free_s;

   cam_free_pick #(.DATA_WIDTH(DATA_WIDTH)) u_free_pick (
      .occ        (occ_r),
      .free_index (free_index_s),
      .any_free   (any_free_s)
   );

   // a CAM match on an entry we consider free is stale and must not report a hit
   assign hit_match_s   = cam_search_valid &  occ_r[cam_search_index];
   assign stale_match_s = cam_search_valid & ~occ_r[cam_search_index];
   assign resp_done_s   = (state_r == ST_RESP) && bus.resp_ready;

   // next state, write-index choice and response fields for this step
   always_comb begin
      state_s   = state_r;
      accept_s  = 1'b0;
      ld_wr_s   = 1'b0;
      wr_idx_s  = {DATA_WIDTH{1'b0}};
      ld_resp_s = 1'b0;
      hit_s     = 1'b0;
      full_s    = 1'b0;
      index_s   = {DATA_WIDTH{1'b0}};
      occ_set_s = 1'b0;
      occ_clr_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_r) begin
               accept_s = 1'b1;
               state_s  = ST_SEARCH;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_SEARCH: begin
            state_s = ST_WAIT;
         end
         ST_WAIT: begin
            state_s = ST_RESP;
            case (op_r)
               CAM_OP_INSERT: begin
                  if (hit_match_s) begin
                     ld_resp_s = 1'b1;
                     hit_s     = 1'b1;
                     index_s   = cam_search_index;
                  end else if (stale_match_s) begin
                     ld_wr_s  = 1'b1;
                     wr_idx_s = cam_search_index;
                     state_s  = ST_WRITE;
                  end else if (any_free_s) begin
                     ld_wr_s  = 1'b1;
                     wr_idx_s = free_index_s;
                     state_s  = ST_WRITE;
                  end else begin
                     ld_resp_s = 1'b1;
                     full_s    = 1'b1;
                  end
               end
               CAM_OP_DELETE: begin
                  ld_resp_s = 1'b1;
                  if (hit_match_s) begin
                     occ_clr_s = 1'b1;
                     hit_s     = 1'b1;
                     index_s   = cam_search_index;
                  end else begin
                     occ_clr_s = 1'b0;
                  end
               end
               default: begin
                  ld_resp_s = 1'b1;
                  if (hit_match_s) begin
                     hit_s   = 1'b1;
                     index_s = cam_search_index;
                  end else begin
                     hit_s   = 1'b0;
                  end
               end
            endcase
         end
         ST_WRITE: begin
            occ_set_s = 1'b1;
            ld_resp_s = 1'b1;
            index_s   = wr_index_r;
            state_s   = ST_RESP;
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state and the request latched at acceptance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         op_r    <= CAM_OP_LOOKUP;
         key_r   <= {DATA_SIZE{1'b0}};
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            op_r  <= cam_decode_op(bus.req_op);
            key_r <= bus.req_key;
         end
      end
   end

   // registered handshake and CAM port outputs, decoded from the next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_ready_r       <= 1'b0;
         resp_valid_r      <= 1'b0;
         cam_search_r      <= 1'b0;
         cam_search_data_r <= {DATA_SIZE{1'b0}};
         cam_write_r       <= 1'b0;
         wr_index_r        <= {DATA_WIDTH{1'b0}};
         cam_write_data_r  <= {DATA_SIZE{1'b0}};
      end else begin
         req_ready_r       <= (state_s == ST_IDLE);
         resp_valid_r      <= (state_s == ST_RESP);
         cam_search_r      <= (state_s == ST_SEARCH);
         cam_search_data_r <= accept_s ? bus.req_key : {DATA_SIZE{1'b0}};
         cam_write_r       <= (state_s == ST_WRITE);
         if (ld_wr_s) begin
            wr_index_r       <= wr_idx_s;
            cam_write_data_r <= key_r;
         end else if (state_r == ST_WRITE) begin
            wr_index_r       <= {DATA_WIDTH{1'b0}};
            cam_write_data_r <= {DATA_SIZE{1'b0}};
         end
      end
   end

   // response fields stay frozen through RESP and return to zero after the handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_hit_r   <= 1'b0;
         resp_full_r  <= 1'b0;
         resp_index_r <= {DATA_WIDTH{1'b0}};
      end else if (ld_resp_s) begin
         resp_hit_r   <= hit_s;
         resp_full_r  <= full_s;
         resp_index_r <= index_s;
      end else if (resp_done_s) begin
         resp_hit_r   <= 1'b0;
         resp_full_r  <= 1'b0;
         resp_index_r <= {DATA_WIDTH{1'b0}};
      end
   end

   // occupancy bits and their running count move on the same edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_r   <= {ENTRIES{1'b0}};
         count_r <= {(DATA_WIDTH + 1){1'b0}};
      end else if (occ_set_s) begin
         occ_r[wr_index_r] <= 1'b1;
         count_r           <= count_r + (DATA_WIDTH + 1)'(1);
      end else if (occ_clr_s) begin
         occ_r[cam_search_index] <= 1'b0;
         count_r                 <= count_r - (DATA_WIDTH + 1)'(1);
      end
   end

`ifdef CAM_INS_STATS_EN
   logic [15:0] hit_cnt_r;
   logic [15:0] miss_cnt_r;

   // one tally per completed response; a full insert reports no hit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_r  <= 16'h0000;
         miss_cnt_r <= 16'h0000;
      end else if (resp_done_s) begin
         if (resp_hit_r) begin
            if (hit_cnt_r != 16'hFFFF) begin
               hit_cnt_r <= hit_cnt_r + 16'h0001;
            end
         end else if (miss_cnt_r != 16'hFFFF) begin
            miss_cnt_r <= miss_cnt_r + 16'h0001;
         end
      end
   end

   assign hit_count  = hit_cnt_r;
   assign miss_count = miss_cnt_r;
`endif

   assign bus.req_ready   = req_ready_r;
   assign bus.resp_valid  = resp_valid_r;
   assign bus.resp_hit    = resp_hit_r;
   assign bus.resp_full   = resp_full_r;
   assign bus.resp_index  = resp_index_r;
   assign occupied_count  = count_r;
   assign cam_search      = cam_search_r;
   assign cam_search_data = cam_search_data_r;
   assign cam_write       = cam_write_r;
   assign cam_write_index = wr_index_r;
   assign cam_write_data  = cam_write_data_r;

endmodule

// File: tb/tb_cam_insert_ctrl.sv
// Scoreboard bench for cam_insert_ctrl: a behavioural CAM, a dictionary-style
// reference model, and a monitor that checks every response and write pulse.
module tb_cam_insert_ctrl;
   import cam_pkg::*;

   localparam int DW = CAM_DATA_WIDTH;
   localparam int DS = CAM_DATA_SIZE;
   localparam int N  = 1 << DW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cam_insert_ctrl_if #(.DATA_WIDTH(DW), .DATA_SIZE(DS)) bus ();

   logic          cam_search;
   logic [DS-1:0] cam_search_data;
   logic          cam_search_valid = 1'b0;
   logic [DW-1:0] cam_search_index = '0;
   logic          cam_write;
   logic [DW-1:0] cam_write_index;
   logic [DS-1:0] cam_write_data;
   logic [DW:0]   occupied_count;
`ifdef CAM_INS_STATS_EN
   logic [15:0]   hit_count;
   logic [15:0]   miss_count;
`endif

   cam_insert_ctrl #(.DATA_WIDTH(DW), .DATA_SIZE(DS)) dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus),
      .occupied_count   (occupied_count),
      .cam_search       (cam_search),
      .cam_search_data  (cam_search_data),
      .cam_search_valid (cam_search_valid),
      .cam_search_index (cam_search_index),
      .cam_write        (cam_write),
      .cam_write_index  (cam_write_index),
      .cam_write_data   (cam_write_data)
`ifdef CAM_INS_STATS_EN
      ,
      .hit_count        (hit_count),
      .miss_count       (miss_count)
`endif
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Behavioural CAM: registered search result, lowest matching written entry wins.
   logic [DS-1:0] cam_mem [N];
   logic [N-1:0]  cam_vld = '0;
   always @(posedge clk) begin
      if (cam_write) begin
         cam_mem[cam_write_index] <= cam_write_data;
         cam_vld[cam_write_index] <= 1'b1;
      end
      if (cam_search) begin
         cam_search_valid <= 1'b0;
         cam_search_index <= '0;
         for (int i = N - 1; i >= 0; i--) begin
            if (cam_vld[i] && cam_mem[i] == cam_search_data) begin
               cam_search_valid <= 1'b1;
               cam_search_index <= DW'(i);
            end
         end
      end
   end

   // Reference model: which key each slot holds and whether the slot is live.
   logic [DS-1:0] ref_key [N];
   bit            ref_written [N];
   bit            ref_occ [N];
   int            ref_hits = 0;
   int            ref_misses = 0;
   int            save_idx = 0;
   bit            save_written = 1'b0;
   logic [DS-1:0] save_key = '0;

   typedef struct { bit hit; bit full; int index; int count; int lat; int acc; } exp_t;
   typedef struct { int idx; logic [DS-1:0] key; } wr_t;
   exp_t exp_q[$];
   wr_t  wr_q[$];

   function automatic int ref_count();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(ref_occ[i]);
      return c;
   endfunction

   task automatic model_op(input logic [1:0] op, input logic [DS-1:0] key, output exp_t e);
      int hit_i = -1;
      int stale_i = -1;
      int free_i = -1;
      for (int i = N - 1; i >= 0; i--) begin
         if (ref_written[i] && ref_key[i] == key) begin
            if (ref_occ[i]) hit_i = i;
            else stale_i = i;
         end
         if (!ref_occ[i]) free_i = i;
      end
      e = '{hit: 1'b0, full: 1'b0, index: 0, count: 0, lat: 3, acc: 0};
      if (op == 2'd1) begin
         if (hit_i >= 0) begin
            e.hit = 1'b1; e.index = hit_i;
         end else if (stale_i >= 0 || free_i >= 0) begin
            e.index = (stale_i >= 0) ? stale_i : free_i;
            e.lat = 4;
            save_idx = e.index; save_written = ref_written[e.index]; save_key = ref_key[e.index];
            ref_occ[e.index] = 1'b1; ref_written[e.index] = 1'b1; ref_key[e.index] = key;
            wr_q.push_back('{idx: e.index, key: key});
         end else begin
            e.full = 1'b1;
         end
      end else if (op == 2'd2) begin
         if (hit_i >= 0) begin
            e.hit = 1'b1; e.index = hit_i; ref_occ[hit_i] = 1'b0;
         end
      end else if (hit_i >= 0) begin
         e.hit = 1'b1; e.index = hit_i;
      end
      e.count = ref_count();
      if (e.hit) ref_hits++;
      else ref_misses++;
   endtask

   task automatic send(input logic [1:0] op, input logic [DS-1:0] key);
      exp_t e;
      int guard = 0;
      model_op(op, key, e);
      @(negedge clk);
      while (!bus.req_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.req_ready) begin
         cmp("req_ready_timeout", {63'd0, bus.req_ready}, 64'd1);
      end else begin
         bus.req_valid = 1'b1;
         bus.req_op    = op;
         bus.req_key   = key;
         e.acc = cyc;
         exp_q.push_back(e);
         @(posedge clk);
         #1;
         bus.req_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int g = 0;
      while ((exp_q.size() != 0 || bus.resp_valid || !bus.req_ready) && g < 500) begin
         @(negedge clk);
         g++;
      end
      if (g >= 500) cmp("idle_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   // 0: always ready, 1: random backpressure, 2: never ready
   int rr_mode = 0;
   initial begin
      bus.resp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rr_mode)
            0:       bus.resp_ready = 1'b1;
            1:       bus.resp_ready = ($urandom_range(0, 2) != 0);
            default: bus.resp_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops expectations whenever the DUT presents a write or a response.
   bit   seen = 1'b0;
   bit   hs_prev = 1'b0;
   exp_t cur;
   wr_t  w;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            seen = 1'b0;
            hs_prev = 1'b0;
         end else begin
            if (hs_prev) cmp("resp_single_cycle", {63'd0, bus.resp_valid}, 64'd0);
            hs_prev = 1'b0;
            if (cam_search || cam_write) cmp("search_write_excl", {63'd0, cam_search & cam_write}, 64'd0);
            if (cam_write) begin
               if (wr_q.size() == 0) begin
                  cmp("unexpected_write", {63'd0, cam_write}, 64'd0);
               end else begin
                  w = wr_q.pop_front();
                  cmp("write_index", 64'(cam_write_index), 64'(w.idx));
                  cmp("write_data", 64'(cam_write_data), 64'(w.key));
               end
            end
            if (bus.resp_valid) begin
               cmp("req_ready_in_resp", {63'd0, bus.req_ready}, 64'd0);
               if (!seen) begin
                  if (exp_q.size() == 0) begin
                     cmp("unexpected_resp", {63'd0, bus.resp_valid}, 64'd0);
                  end else begin
                     cur = exp_q.pop_front();
                     cmp("resp_latency", 64'(cyc - cur.acc), 64'(cur.lat));
                  end
                  seen = 1'b1;
               end
               cmp("resp_hit", {63'd0, bus.resp_hit}, {63'd0, cur.hit});
               cmp("resp_full", {63'd0, bus.resp_full}, {63'd0, cur.full});
               cmp("resp_index", 64'(bus.resp_index), 64'(cur.index));
               cmp("occupied_count", 64'(occupied_count), 64'(cur.count));
               if (bus.resp_ready) begin
                  seen = 1'b0;
                  hs_prev = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      int g;
      logic [1:0]    op;
      logic [DS-1:0] key;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'd0;
      bus.req_key   = '0;
      for (int i = 0; i < N; i++) begin
         ref_key[i] = '0; ref_written[i] = 1'b0; ref_occ[i] = 1'b0;
      end

      repeat (3) @(negedge clk);
      cmp("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
      cmp("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      cmp("rst_occupied", 64'(occupied_count), 64'd0);
      cmp("rst_cam_write", {63'd0, cam_write}, 64'd0);
      cmp("rst_cam_search", {63'd0, cam_search}, 64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      cmp("idle_req_ready", {63'd0, bus.req_ready}, 64'd1);

      // directed: first lookup/insert, fill to capacity, full insert, stale reuse
      rr_mode = 0;
      send(2'd0, 32'd7);
      send(2'd1, 32'd7);
      send(2'd0, 32'd7);
      send(2'd3, 32'd7);
      send(2'd2, 32'd7);
      for (int i = 0; i < N; i++) send(2'd1, 32'h100 + 32'(i));
      send(2'd1, 32'h200);
      send(2'd2, 32'h103);
      send(2'd2, 32'h105);
      send(2'd0, 32'h105);
      send(2'd1, 32'h105);
      send(2'd1, 32'h103);
      wait_idle();

      // response held under backpressure
      rr_mode = 2;
      send(2'd0, 32'h110);
      g = 0;
      while (!bus.resp_valid && g < 20) begin
         @(negedge clk);
         g++;
      end
      cmp("hold_resp_seen", {63'd0, bus.resp_valid}, 64'd1);
      repeat (10) @(negedge clk);
      rr_mode = 0;
      wait_idle();

      // randomized mix over a key pool larger than the CAM
      rr_mode = 1;
      repeat (300) begin
         op  = 2'($urandom_range(0, 3));
         key = ($urandom_range(0, 3) == 0) ? DS'($urandom) : 32'h100 + 32'($urandom_range(0, 47));
         send(op, key);
      end
      wait_idle();

      // reset in the middle of a write
      rr_mode = 0;
      if (ref_count() == N) begin
         send(2'd2, ref_key[0]);
         wait_idle();
      end
      send(2'd1, 32'hDEAD_BEEF);
      g = 0;
      @(negedge clk);
      while (!cam_write && g < 20) begin
         @(negedge clk);
         g++;
      end
      cmp("abort_saw_write", {63'd0, cam_write}, 64'd1);
      rst = 1'b0;
      #1;
      cmp("abort_write_drop", {63'd0, cam_write}, 64'd0);
      cmp("abort_occupied", 64'(occupied_count), 64'd0);
      cmp("abort_req_ready", {63'd0, bus.req_ready}, 64'd0);
      cmp("abort_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      ref_written[save_idx] = save_written;
      ref_key[save_idx] = save_key;
      for (int i = 0; i < N; i++) ref_occ[i] = 1'b0;
      exp_q.delete();
      wr_q.delete();
      ref_hits = 0;
      ref_misses = 0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // traffic after reset, with stale CAM contents still present
      rr_mode = 1;
      repeat (80) begin
         op  = 2'($urandom_range(0, 3));
         key = 32'h100 + 32'($urandom_range(0, 47));
         send(op, key);
      end
      wait_idle();

      cmp("final_exp_queue", 64'(exp_q.size()), 64'd0);
      cmp("final_wr_queue", 64'(wr_q.size()), 64'd0);
      cmp("final_occupied", 64'(occupied_count), 64'(ref_count()));
`ifdef CAM_INS_STATS_EN
      cmp("hit_count", 64'(hit_count), 64'(ref_hits));
      cmp("miss_count", 64'(miss_count), 64'(ref_misses));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cam_insert_ctrl.md
# cam_insert_ctrl

Request-side controller sitting directly upstream of the `cam` block. It accepts key operations (lookup, insert, delete) over a valid/ready handshake, sequences the `cam` search and write ports, and tracks entry occupancy. It allocates the lowest free entry on an insert miss and returns hit, index and full status over a valid/ready response channel.

## Interface
- `DATA_WIDTH`, 5: index width; the `cam` holds `1 << DATA_WIDTH` entries.
- `DATA_SIZE`, `1 << DATA_WIDTH`: key width in bits; must match `cam`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_op`  in  2  operation: 0 = LOOKUP, 1 = INSERT, 2 = DELETE; 3 is treated as LOOKUP.
- `req_key`  in  DATA_SIZE  key.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_hit`  out  1  key was present and occupied.
- `resp_full`  out  1  insert missed and no free entry existed.
- `resp_index`  out  DATA_WIDTH  hit index, or allocated index on an insert miss; 0 otherwise.
- `occupied_count`  out  DATA_WIDTH+1  number of occupied entries.
- `cam_search`, `cam_search_data`  out  1 / DATA_SIZE  drive `cam.search` and `cam.search_data`.
- `cam_search_valid`, `cam_search_index`  in  1 / DATA_WIDTH  from `cam`.
- `cam_write`, `cam_write_index`, `cam_write_data`  out  1 / DATA_WIDTH / DATA_SIZE  drive the `cam` write port.

## Operation
- Local `occ` vector of `1 << DATA_WIDTH` bits; all entries are free at reset.
- A `cam` match counts as a hit only if `occ[cam_search_index]` is set. A match on an unoccupied entry is a stale match.
- FSM states: IDLE, SEARCH, WAIT, WRITE, RESP.
  - **IDLE**: `req_ready = 1`. When `req_valid` is high, latch `req_op` and `req_key`, then go to SEARCH.
  - **SEARCH**: `cam_search = 1` and `cam_search_data` = key for exactly one cycle, then go to WAIT.
  - **WAIT**: sample the `cam` result.
    - LOOKUP: go to RESP.
    - INSERT hit: go to RESP.
    - INSERT stale match: reuse that index, go to WRITE.
    - INSERT miss with a free entry: take the lowest-numbered free index, go to WRITE.
    - INSERT miss with no free entry: `resp_full = 1`, go to RESP.
    - DELETE hit: clear the `occ` bit, go to RESP.
    - DELETE miss: go to RESP.
  - **WRITE**: `cam_write = 1` for one cycle with the chosen index and key; set the `occ` bit. Go to RESP with `resp_hit = 0`.
  - **RESP**: hold `resp_valid` and all response fields stable until `resp_ready` is high, then go to IDLE.
- `occupied_count` updates on the same edge as its `occ` bit.
- `cam_search` and `cam_write` are never asserted in the same cycle.

## Timing
- Reset values: `req_ready = 0` while `rst` is low and 1 in IDLE after release. All other outputs are 0, `occ` is clear, and the state is IDLE.
- Reset is asynchronous: mid-operation reset drops `cam_write` and `cam_search` immediately and discards the transaction in flight.
- Request accepted at edge N: SEARCH in cycle N+1, result sampled in cycle N+2 (the `cam` registers its search result). RESP starts in cycle N+3, or N+4 when WRITE occurs.
- Minimum turnaround is 4 cycles per request; only one request is in flight at a time.
- If `resp_ready` is already high when RESP is entered, RESP lasts exactly one cycle.

## Configuration
- `CAM_INS_STATS_EN` defined: adds outputs `hit_count` and `miss_count`, 16 bits each, saturating at 0xFFFF and cleared by reset. They increment once per response in RESP, on the `resp_ready` handshake; a full insert counts as a miss.
- `CAM_INS_STATS_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `cam_pkg`:
  - the `DATA_WIDTH`/`DATA_SIZE` defaults;
  - an op enum (`CAM_OP_LOOKUP`, `CAM_OP_INSERT`, `CAM_OP_DELETE`);
  - the FSM state enum.
- Sub-module `cam_free_pick`: a combinational lowest-set-bit priority encoder over `~occ`, with outputs `free_index` and `any_free`.

## Test plan
- After reset, LOOKUP key 7 -> `resp_hit = 0`, `resp_index = 0`, `occupied_count = 0`, and `resp_valid` first asserts 3 cycles after acceptance.
- INSERT key 7 -> `cam_write` pulses with index 0 and data 7; response has `resp_hit = 0`, `resp_index = 0`, and `occupied_count = 1`. A subsequent LOOKUP 7 -> `resp_hit = 1`, `resp_index = 0`.
- Fill 32 distinct keys (0x100..0x11F), then INSERT 0x200 -> `resp_full = 1`, no `cam_write`, `occupied_count = 32`.
- DELETE 0x105 (index 5), then LOOKUP 0x105 -> `resp_hit = 0`. INSERT 0x105 again -> `cam_write_index = 5` (stale reuse) and `occupied_count` returns to 32.
- Hold `resp_ready = 0` for 10 cycles -> `resp_valid` and all response fields stay stable and `req_ready` stays 0. Drop `rst` during WRITE -> `cam_write` falls within the same cycle and `occupied_count = 0`.
- With `CAM_INS_STATS_EN` defined: 3 hits and 2 misses -> `hit_count = 3`, `miss_count = 2`.
